shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data width of shared shifter.
REQ-002 SHALL have parameter SW, default 5, shift-amount width, equal to log2(DW).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have, for each requester k in {0,1}, port rk_req_valid  input  1  request present.
REQ-006 SHALL have rk_req_ready  output  1  request accepted this cycle when high with rk_req_valid.
REQ-007 SHALL have rk_din  input  DW  operand to shift.
REQ-008 SHALL have rk_shamt  input  SW  shift amount.
REQ-009 SHALL have rk_arith  input  1  1 = arithmetic (sign-fill) right shift, 0 = logical.
REQ-010 SHALL have rk_left  input  1  1 = left shift, 0 = right shift.
REQ-011 SHALL have rk_resp_valid  output  1  result for requester k held in output register.
REQ-012 SHALL have rk_resp_ready  input  1  requester k consumes result this cycle.
REQ-013 SHALL have rk_dout  output  DW  shifted result; valid only while rk_resp_valid.
REQ-014 SHALL have busy  output  1  high whenever a response is pending (state BUSY).

Function
REQ-015 SHALL share exactly one combinational shifter between both requesters; one operation per accepted request.
REQ-016 SHALL implement FSM states IDLE (no pending result) and BUSY (result register holds result for owner).
REQ-017 IDLE: rk_req_ready SHALL equal the arbiter grant for k; a handshake SHALL move to BUSY.
REQ-018 BUSY: rk_req_ready SHALL be high only when owner's resp_ready is high this cycle and k is granted (back-to-back issue); else low.
REQ-019 BUSY with owner resp_ready high and no new handshake SHALL return to IDLE; with new handshake SHALL stay BUSY with new owner/result.
REQ-020 Latency SHALL be exactly 1 cycle: request accepted at edge N → resp_valid high from edge N+1 with result registered.
REQ-021 Sustained throughput SHALL be 1 op/cycle when responses are consumed immediately.
REQ-022 Arbitration SHALL be round-robin: single valid requester wins; both valid → requester not granted last wins; last-grant pointer updates only on handshake.
REQ-023 Only the owner's rk_resp_valid SHALL be high; the other SHALL be 0.
REQ-024 Result SHALL be: left = din << shamt zero-fill; right logical = zero-fill; right arithmetic = fill with din[DW-1]; arith ignored when left=1.
REQ-025 shamt = 0 SHALL return din unchanged for all modes.
REQ-026 rk_dout, owner and result SHALL remain stable while resp_valid high and resp_ready low.
REQ-027 Requesters SHALL hold valid and operands stable until ready; block need not tolerate violations (bench asserts).

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, both resp_valid 0, both dout 0, busy 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-029 Reset during BUSY SHALL discard the pending result without handshake.
REQ-030 req_ready outputs SHALL be 0 while rst_n low.

Structure
REQ-031 Shared package SHALL hold FSM state encoding (IDLE, BUSY) and requester-ID constants (REQ0, REQ1).
REQ-032 SHALL instantiate the team's barrel_shifter (DW, SW passed through) as the single sub-module; mode inputs AL_sel = arith, LR_sel = left, driven from grant mux.

Verification
REQ-033 r0 only: din=0x8000_0010, shamt=4, arith=1, left=0 → r0_resp_valid next cycle, r0_dout=0xF800_0001.
REQ-034 Both valid after reset: r0 left shamt=1 din=1, r1 right logical shamt=31 din=0x8000_0000 → r0 served first (dout=2), r1 next (dout=1).
REQ-035 Back-to-back: r0 valid 4 cycles, resp_ready held 1 → 4 results on 4 consecutive cycles, busy stays 1.
REQ-036 Backpressure: r1 result pending, r1_resp_ready=0 for 3 cycles → r1_dout stable, both req_ready 0, r0 request waits.
REQ-037 Boundaries: shamt=0 all modes → dout=din; left with arith=1 din=0xFFFF_FFFF shamt=31 → 0x8000_0000.
REQ-038 rst_n low mid-BUSY → resp_valid 0 immediately; after release, tie grants r0 first.

Source files
------------

// File: rtl/shift_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter_pkg
// Description : Shared types and constants for the two-requester shift
//               arbiter: FSM state encoding and requester identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_arbiter_pkg;

    // IDLE: no result pending; BUSY: result register holds a result for its owner
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Requester identifiers, also used as the owner / last-grant encoding
    localparam logic c_REQ0 = 1'b0;
    localparam logic c_REQ1 = 1'b1;

endpackage : shift_arbiter_pkg
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shifter
// Description : Combinational logarithmic barrel shifter. Left shifts are
//               done by bit-reversing around a right-shift core so one set of
//               stages serves both directions. AL_sel selects sign fill for
//               right shifts and is ignored for left shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter #(
    parameter int DW = 32,
    parameter int SW = 5
) (
    input  logic [DW-1:0] din,
    input  logic [SW-1:0] shamt,
    input  logic          AL_sel,
    input  logic          LR_sel,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] w_rev_in;
    logic [DW-1:0] w_rev_out;
    logic [DW-1:0] w_stage [SW+1];
    logic          w_fill;

    // Bit reversal of the operand and of the final stage, used for left shifts
    generate
        for (genvar i = 0; i < DW; i++) begin : g_rev
            assign w_rev_in[i]  = din[DW-1-i];
            assign w_rev_out[i] = w_stage[SW][DW-1-i];
        end
    endgenerate

    // Sign fill only for arithmetic right shifts; left shifts always zero-fill
    assign w_fill     = AL_sel & ~LR_sel & din[DW-1];
    assign w_stage[0] = LR_sel ? w_rev_in : din;

    // Stage s conditionally shifts right by 2**s
    generate
        for (genvar s = 0; s < SW; s++) begin : g_stage
            localparam int c_STEP = 1 << s;
            assign w_stage[s+1] = shamt[s] ? {{c_STEP{w_fill}}, w_stage[s][DW-1:c_STEP]}
                                           : w_stage[s];
        end
    endgenerate

    assign dout = LR_sel ? w_rev_out : w_stage[SW];

endmodule : barrel_shifter
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shift_arbiter
// Description : Round-robin arbiter sharing one barrel shifter between two
//               requesters. Accepted requests produce a registered result one
//               cycle later; a consumed result may be replaced in the same
//               cycle for one operation per cycle throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DW = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req_valid,
    output logic          r0_req_ready,
    input  logic [DW-1:0] r0_din,
    input  logic [SW-1:0] r0_shamt,
    input  logic          r0_arith,
    input  logic          r0_left,
    output logic          r0_resp_valid,
    input  logic          r0_resp_ready,
    output logic [DW-1:0] r0_dout,
    input  logic          r1_req_valid,
    output logic          r1_req_ready,
    input  logic [DW-1:0] r1_din,
    input  logic [SW-1:0] r1_shamt,
    input  logic          r1_arith,
    input  logic          r1_left,
    output logic          r1_resp_valid,
    input  logic          r1_resp_ready,
    output logic [DW-1:0] r1_dout,
    output logic          busy
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_owner;
    logic          r_last;
    logic [DW-1:0] r_dout;

    logic          w_gnt_vld;
    logic          w_gnt_id;
    logic          w_owner_rdy;
    logic          w_issue_ok;
    logic          w_hs;
    logic [DW-1:0] w_sel_din;
    logic [SW-1:0] w_sel_shamt;
    logic          w_sel_arith;
    logic          w_sel_left;
    logic [DW-1:0] w_shift_out;

    // Round-robin grant: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        w_gnt_vld = r0_req_valid | r1_req_valid;
        if (r0_req_valid && r1_req_valid) begin
            w_gnt_id = ~r_last;
        end else if (r1_req_valid) begin
            w_gnt_id = c_REQ1;
        end else begin
            w_gnt_id = c_REQ0;
        end
    end

    // Operand mux feeding the single shared shifter from the granted requester
    always_comb begin
        if (w_gnt_id == c_REQ1) begin
            w_sel_din   = r1_din;
            w_sel_shamt = r1_shamt;
            w_sel_arith = r1_arith;
            w_sel_left  = r1_left;
        end else begin
            w_sel_din   = r0_din;
            w_sel_shamt = r0_shamt;
            w_sel_arith = r0_arith;
            w_sel_left  = r0_left;
        end
    end

    barrel_shifter #(
        .DW (DW),
        .SW (SW)
    ) u_barrel_shifter (
        .din    (w_sel_din),
        .shamt  (w_sel_shamt),
        .AL_sel (w_sel_arith),
        .LR_sel (w_sel_left),
        .dout   (w_shift_out)
    );

    // Next state and request handshakes; a new issue in BUSY needs the owner to drain
    always_comb begin
        w_state_nxt  = r_state;
        w_issue_ok   = 1'b0;
        w_owner_rdy  = (r_owner == c_REQ1) ? r1_resp_ready : r0_resp_ready;
        case (r_state)
            IDLE:    w_issue_ok = 1'b1;
            BUSY:    w_issue_ok = w_owner_rdy;
            default: w_issue_ok = 1'b0;
        endcase
        // rst_n gates the handshake so no ready is shown while held in reset
        w_hs         = rst_n & w_issue_ok & w_gnt_vld;
        r0_req_ready = w_hs & (w_gnt_id == c_REQ0);
        r1_req_ready = w_hs & (w_gnt_id == c_REQ1);
        if (w_hs) begin
            w_state_nxt = BUSY;
        end else if ((r_state == BUSY) && w_owner_rdy) begin
            w_state_nxt = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result, owner and last-grant registers, loaded only on a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= c_REQ0;
            r_last  <= c_REQ1;
            r_dout  <= '0;
        end else if (w_hs) begin
            r_owner <= w_gnt_id;
            r_last  <= w_gnt_id;
            r_dout  <= w_shift_out;
        end
    end

    assign busy          = (r_state == BUSY);
    assign r0_resp_valid = busy & (r_owner == c_REQ0);
    assign r1_resp_valid = busy & (r_owner == c_REQ1);
    assign r0_dout       = r_dout;
    assign r1_dout       = r_dout;

endmodule : shift_arbiter
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_arbiter
// Description : Self-checking bench for shift_arbiter. Directed scenarios with
//               literal expectations, then randomized protocol-respecting
//               traffic compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    localparam int DW = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic          r0_req_ready, r1_req_ready;
    logic [DW-1:0] r0_din = '0, r1_din = '0;
    logic [SW-1:0] r0_shamt = '0, r1_shamt = '0;
    logic          r0_arith = 1'b0, r1_arith = 1'b0;
    logic          r0_left = 1'b0, r1_left = 1'b0;
    logic          r0_resp_valid, r1_resp_valid;
    logic          r0_resp_ready = 1'b1, r1_resp_ready = 1'b1;
    logic [DW-1:0] r0_dout, r1_dout;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    // Model state: pending result, its owner and value, last granted requester
    logic          m_busy, m_owner, m_last, m_acc0, m_acc1;
    logic [31:0]   m_res;

    logic [31:0]   exp035 [4] = '{32'h11, 32'h22, 32'h44, 32'h88};

    shift_arbiter #(.DW(DW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
        .r0_din(r0_din), .r0_shamt(r0_shamt), .r0_arith(r0_arith), .r0_left(r0_left),
        .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready), .r0_dout(r0_dout),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
        .r1_din(r1_din), .r1_shamt(r1_shamt), .r1_arith(r1_arith), .r1_left(r1_left),
        .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready), .r1_dout(r1_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference shift: right shifts done on a 64-bit sign/zero-extended value
    function automatic logic [31:0] shift_ref(input logic [31:0] din, input logic [4:0] sh,
                                              input logic ar, input logic lf);
        logic [63:0] ext;
        if (lf) return din << sh;
        ext = (ar && din[31]) ? {32'hFFFF_FFFF, din} : {32'h0, din};
        ext = ext >> sh;
        return ext[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, then advance the model past the next edge
    always @(negedge clk) begin : p_compare
        logic gv, gid, ordy, iss, e0, e1;
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_acc0 = 1'b0; m_acc1 = 1'b0;
            m_res = '0;
            chk("rst_busy",   {31'b0, busy},          32'h0);
            chk("rst_rv0",    {31'b0, r0_resp_valid}, 32'h0);
            chk("rst_rv1",    {31'b0, r1_resp_valid}, 32'h0);
            chk("rst_rdy0",   {31'b0, r0_req_ready},  32'h0);
            chk("rst_rdy1",   {31'b0, r1_req_ready},  32'h0);
            chk("rst_dout0",  r0_dout, 32'h0);
            chk("rst_dout1",  r1_dout, 32'h0);
        end else begin
            gv   = r0_req_valid | r1_req_valid;
            gid  = (r0_req_valid && r1_req_valid) ? ~m_last : r1_req_valid;
            ordy = m_owner ? r1_resp_ready : r0_resp_ready;
            iss  = !m_busy || ordy;
            e0   = iss && gv && !gid;
            e1   = iss && gv && gid;
            chk("busy",     {31'b0, busy},          {31'b0, m_busy});
            chk("rv0",      {31'b0, r0_resp_valid}, {31'b0, m_busy && !m_owner});
            chk("rv1",      {31'b0, r1_resp_valid}, {31'b0, m_busy && m_owner});
            chk("rdy0",     {31'b0, r0_req_ready},  {31'b0, e0});
            chk("rdy1",     {31'b0, r1_req_ready},  {31'b0, e1});
            if (m_busy) chk(m_owner ? "dout1" : "dout0", m_owner ? r1_dout : r0_dout, m_res);
            m_acc0 = e0;
            m_acc1 = e1;
            if (m_busy && ordy) m_busy = 1'b0;
            if (e0 || e1) begin
                m_busy  = 1'b1;
                m_owner = gid;
                m_last  = gid;
                m_res   = gid ? shift_ref(r1_din, r1_shamt, r1_arith, r1_left)
                              : shift_ref(r0_din, r0_shamt, r0_arith, r0_left);
            end
        end
    end

    task automatic set_req(input logic k, input logic [31:0] d, input logic [4:0] sh,
                           input logic ar, input logic lf);
        if (k) begin
            r1_req_valid = 1'b1; r1_din = d; r1_shamt = sh; r1_arith = ar; r1_left = lf;
        end else begin
            r0_req_valid = 1'b1; r0_din = d; r0_shamt = sh; r0_arith = ar; r0_left = lf;
        end
    endtask

    // Issue one request on requester k, wait (bounded) for acceptance, check the result
    task automatic issue(input string name, input logic k, input logic [31:0] d,
                         input logic [4:0] sh, input logic ar, input logic lf,
                         input logic [31:0] exp);
        int n;
        @(posedge clk); #1;
        set_req(k, d, sh, ar, lf);
        if (k) r1_resp_ready = 1'b1; else r0_resp_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(k ? r1_req_ready : r0_req_ready) && n < 20);
        if (n >= 20) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: got no ready, expected ready within 20 cycles", name);
        end
        @(posedge clk); #1;
        if (k) r1_req_valid = 1'b0; else r0_req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_rv"}, {31'b0, k ? r1_resp_valid : r0_resp_valid}, 32'h1);
        chk({name, "_dout"}, k ? r1_dout : r0_dout, exp);
    endtask

    function automatic logic [4:0] pick_sh();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 5'd0;
        if (r == 1) return 5'd31;
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        // Reset: a request held during reset must not be shown ready
        set_req(1'b0, 32'h1234_5678, 5'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_hold_rdy0", {31'b0, r0_req_ready}, 32'h0);
        @(posedge clk); #1;
        r0_req_valid = 1'b0;
        rst_n = 1'b1;

        // Arithmetic right shift on r0
        issue("arith_r0", 1'b0, 32'h8000_0010, 5'd4, 1'b1, 1'b0, 32'hF800_0001);

        // Tie after reset: r0 first, then r1
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b1;
        set_req(1'b0, 32'h1, 5'd1, 1'b0, 1'b1);
        set_req(1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
        @(negedge clk);
        chk("tie_rdy0", {31'b0, r0_req_ready}, 32'h1);
        chk("tie_rdy1", {31'b0, r1_req_ready}, 32'h0);
        @(posedge clk); #1; r0_req_valid = 1'b0;
        @(negedge clk);
        chk("tie_dout0", r0_dout, 32'h2);
        chk("tie_rv0",   {31'b0, r0_resp_valid}, 32'h1);
        chk("tie_b2b_rdy1", {31'b0, r1_req_ready}, 32'h1);
        @(posedge clk); #1; r1_req_valid = 1'b0;
        @(negedge clk);
        chk("tie_rv1",   {31'b0, r1_resp_valid}, 32'h1);
        chk("tie_rv0_lo", {31'b0, r0_resp_valid}, 32'h0);
        chk("tie_dout1", r1_dout, 32'h1);

        // Back-to-back: four results on four consecutive cycles
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4) set_req(1'b0, 32'h11, 5'(i), 1'b0, 1'b1);
            else r0_req_valid = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_rv0",  {31'b0, r0_resp_valid}, 32'h1);
                chk("b2b_dout", r0_dout, exp035[i-1]);
                chk("b2b_busy", {31'b0, busy}, 32'h1);
            end
        end

        // Backpressure on r1 while r0 waits
        @(posedge clk); #1;
        set_req(1'b1, 32'hA5A5_0000, 5'd8, 1'b0, 1'b0);
        r1_resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_rdy1", {31'b0, r1_req_ready}, 32'h1);
        @(posedge clk); #1;
        r1_req_valid = 1'b0;
        set_req(1'b0, 32'h3, 5'd2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rv1",   {31'b0, r1_resp_valid}, 32'h1);
            chk("bp_dout1", r1_dout, 32'h00A5_A500);
            chk("bp_rdy0",  {31'b0, r0_req_ready}, 32'h0);
            chk("bp_rdy1_lo", {31'b0, r1_req_ready}, 32'h0);
            if (i < 2) @(posedge clk);
        end
        @(posedge clk); #1; r1_resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy0", {31'b0, r0_req_ready}, 32'h1);
        @(posedge clk); #1; r0_req_valid = 1'b0;
        @(negedge clk);
        chk("bp_dout0", r0_dout, 32'hC);
        chk("bp_rv1_lo", {31'b0, r1_resp_valid}, 32'h0);

        // Boundaries: shamt 0 in all modes, and left with arith set
        for (int m = 0; m < 4; m++) begin
            issue("sh0", 1'(m), 32'h8765_4321, 5'd0, 1'(m >> 1), 1'(m), 32'h8765_4321);
        end
        issue("left_arith", 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 32'h8000_0000);

        // Reset in the middle of BUSY discards the pending result
        @(posedge clk); #1;
        set_req(1'b0, 32'h0000_00F0, 5'd4, 1'b0, 1'b0);
        r0_resp_ready = 1'b0;
        @(negedge clk);
        chk("mid_rdy0", {31'b0, r0_req_ready}, 32'h1);
        @(posedge clk); #1; r0_req_valid = 1'b0;
        @(negedge clk);
        chk("mid_dout0", r0_dout, 32'hF);
        @(posedge clk); #3;
        rst_n = 1'b0;
        set_req(1'b0, 32'h5, 5'd1, 1'b0, 1'b1);
        set_req(1'b1, 32'hF000_0000, 5'd4, 1'b1, 1'b0);
        #1;
        chk("mid_rst_rv0",  {31'b0, r0_resp_valid}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1; r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy0", {31'b0, r0_req_ready}, 32'h1);
        chk("post_rst_rdy1", {31'b0, r1_req_ready}, 32'h0);
        @(posedge clk); #1; r0_req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_dout0", r0_dout, 32'hA);
        chk("post_rst_rdy1b", {31'b0, r1_req_ready}, 32'h1);
        @(posedge clk); #1; r1_req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_dout1", r1_dout, 32'hFF00_0000);

        // Randomized traffic; requests are held until accepted
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n = (c % 500 == 250) ? 1'b0 : 1'b1;
            if (!r0_req_valid || m_acc0) begin
                r0_req_valid = ($urandom_range(0, 3) != 0);
                r0_din = $urandom; r0_shamt = pick_sh();
                r0_arith = 1'($urandom_range(0, 1)); r0_left = 1'($urandom_range(0, 1));
            end
            if (!r1_req_valid || m_acc1) begin
                r1_req_valid = ($urandom_range(0, 3) != 0);
                r1_din = $urandom; r1_shamt = pick_sh();
                r1_arith = 1'($urandom_range(0, 1)); r1_left = 1'($urandom_range(0, 1));
            end
            r0_resp_ready = ($urandom_range(0, 3) != 0);
            r1_resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_shift_arbiter
`default_nettype wire
